// File: rtl/mult_iter_counter.sv
// mult_iter_counter: iteration counter for the shift-add multiplier datapath.
// Load restarts the count from zero and arms the counter. K flags that
// ITERATIONS steps have completed since the last Load.
// Optional build macro ITER_COUNTER_PULSE_EN: K becomes a single-cycle pulse on
// the completion edge instead of a level held until the next Load or reset.
module mult_iter_counter #(
    parameter int unsigned ITERATIONS = 32,
    localparam int unsigned CNT_W = $clog2(ITERATIONS + 1)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Load,
    output logic             K,
    output logic [CNT_W-1:0] Count,
    output logic             Busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERATIONS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             k_q, k_d;
    logic             busy_q, busy_d;

    // Next-state and registered-output computation; Load overrides every state.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        k_d     = k_q;
        busy_d  = busy_q;
        if (Load) begin
            state_d = S_COUNT;
            count_d = '0;
            k_d     = 1'b0;
            busy_d  = 1'b1;
        end else begin
            unique case (state_q)
                S_COUNT: begin
                    count_d = count_q + CNT_W'(1);
                    if (count_d == LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        k_d     = 1'b1;
                    end
                end
                S_DONE: begin
`ifdef ITER_COUNTER_PULSE_EN
                    k_d = 1'b0;
`else
                    k_d = k_q;
`endif
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; asynchronous active-low reset returns to idle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            k_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
        end
    end

    assign K     = k_q;
    assign Count = count_q;
    assign Busy  = busy_q;

endmodule

// File: tb/tb_mult_iter_counter.sv
// Directed testbench for mult_iter_counter with ITERATIONS=8.
module tb_mult_iter_counter;

    localparam int unsigned ITER = 8;
    localparam int unsigned CW   = $clog2(ITER + 1);

`ifdef ITER_COUNTER_PULSE_EN
    localparam logic K_HOLD = 1'b0;
`else
    localparam logic K_HOLD = 1'b1;
`endif

    logic          Clk;
    logic          Rst_n;
    logic          Load;
    logic          K;
    logic [CW-1:0] Count;
    logic          Busy;

    int errors = 0;
    int checks = 0;

    mult_iter_counter #(.ITERATIONS(ITER)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Load  (Load),
        .K     (K),
        .Count (Count),
        .Busy  (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ec, input logic ek, input logic eb);
        chk({tag, ".count"}, 32'(Count), 32'(ec));
        chk({tag, ".k"},     32'(K),     32'(ek));
        chk({tag, ".busy"},  32'(Busy),  32'(eb));
    endtask

    initial begin
        Rst_n = 1'b0;
        Load  = 1'b0;

        // 1: reset, then idle with Load low
        repeat (2) @(negedge Clk);
        chk_all("reset", 0, 1'b0, 1'b0);
        Rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk_all("idle", 0, 1'b0, 1'b0);
        end

        // 2: load and count to completion
        Load = 1'b1;
        @(negedge Clk);
        chk_all("load1", 0, 1'b0, 1'b1);
        Load = 1'b0;
        for (int i = 1; i <= int'(ITER); i++) begin
            @(negedge Clk);
            chk_all("cnt", i, (i == int'(ITER)), (i < int'(ITER)));
        end

        // 3: saturation after completion
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk_all("sat", ITER, K_HOLD, 1'b0);
        end

        // Load while done clears K on that edge
        Load = 1'b1;
        @(negedge Clk);
        chk_all("load_done", 0, 1'b0, 1'b1);
        Load = 1'b0;

        // 4: reload mid-count restarts from zero
        repeat (4) @(negedge Clk);
        chk_all("mid4", 4, 1'b0, 1'b1);
        Load = 1'b1;
        @(negedge Clk);
        chk_all("reload", 0, 1'b0, 1'b1);
        Load = 1'b0;
        repeat (ITER - 1) @(negedge Clk);
        chk_all("pre_k", ITER - 1, 1'b0, 1'b1);
        @(negedge Clk);
        chk_all("k_after_reload", ITER, 1'b1, 1'b0);

        // 5: asynchronous reset mid-count
        Load = 1'b1;
        @(negedge Clk);
        Load = 1'b0;
        repeat (5) @(negedge Clk);
        chk_all("mid5", 5, 1'b0, 1'b1);
        #2 Rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 1'b0, 1'b0);
        #1 Rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            chk_all("post_rst_idle", 0, 1'b0, 1'b0);
        end

        // 6: Load held during reset, then released
        Rst_n = 1'b0;
        Load  = 1'b1;
        repeat (2) @(negedge Clk);
        chk_all("rst_wins", 0, 1'b0, 1'b0);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk_all("rel_load", 0, 1'b0, 1'b1);
        Load = 1'b0;
        @(negedge Clk);
        chk_all("rel_cnt1", 1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
